// File: rtl/calc_key_engine.sv
// calc_key_engine: keypad key consumer and 16-bit signed calculator core.
// Takes one key per KeyRdy/KeyRd handshake, builds decimal operands,
// latches the operator and evaluates on equal or on a chained operator.
// Optional feature macro: CALC_MUL_EN (operator 011 multiplies when defined).
module calc_key_engine (
  input  logic        clk,
  input  logic        nRST,
  input  logic        KeyRdy,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        KeyRd,
  output logic [15:0] display,
  output logic        ovf,
  output logic        result_valid
);

  typedef enum logic [1:0] {ENTER_A, OP_WAIT, ENTER_B, RESULT} state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;

  state_t             state, nxt_state;
  logic signed [15:0] acc_a, acc_b, nxt_a, nxt_b;
  logic [2:0]         op, nxt_op;
  logic               nxt_ovf;
  logic               armed, cap;

  // datapath intermediates
  logic signed [15:0] cur, neg, res;
  logic signed [31:0] wa, wb, wc, dg, full, appended;
  logic               in_rng, eovf, arith;

  // A key is taken only once KeyRdy has been seen low since the last capture
  assign cap = KeyRdy && armed;

  assign display      = (state == ENTER_B) ? acc_b : acc_a;
  assign result_valid = (state == RESULT);

  // Evaluation, digit append and negate for the operand in play
  always_comb begin
    cur      = (state == ENTER_B) ? acc_b : acc_a;
    wa       = acc_a;
    wb       = (state == OP_WAIT) ? acc_a : acc_b;
    wc       = cur;
    dg       = {28'd0, keypad_input};
    appended = (cur < 0) ? (wc * 32'sd10 - dg) : (wc * 32'sd10 + dg);
    in_rng   = (appended >= -32'sd32768) && (appended <= 32'sd32767);
    neg      = -cur;
    case (op)
      OP_ADD:  full = wa + wb;
      OP_SUB:  full = wa - wb;
`ifdef CALC_MUL_EN
      OP_MUL:  full = wa * wb;
`endif
      default: full = wa;
    endcase
    res  = full[15:0];
    eovf = (full != {{16{res[15]}}, res});
`ifdef CALC_MUL_EN
    arith = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
            (operator_input == OP_MUL);
`else
    arith = (operator_input == OP_ADD) || (operator_input == OP_SUB);
`endif
  end

  // Next-state and register updates for a captured key
  always_comb begin
    nxt_state = state;
    nxt_a     = acc_a;
    nxt_b     = acc_b;
    nxt_op    = op;
    nxt_ovf   = ovf;
    if (cap) begin
      if (equal_input) begin
        case (state)
          OP_WAIT: begin
            nxt_b     = acc_a;
            nxt_a     = res;
            nxt_ovf   = eovf;
            nxt_state = RESULT;
          end
          ENTER_B, RESULT: begin
            nxt_a     = res;
            nxt_ovf   = eovf;
            nxt_state = RESULT;
          end
          default: ;
        endcase
      end else if (operator_input == OP_CLR) begin
        nxt_a     = '0;
        nxt_b     = '0;
        nxt_op    = '0;
        nxt_ovf   = 1'b0;
        nxt_state = ENTER_A;
      end else if (operator_input == OP_NEG) begin
        if (state != OP_WAIT) begin
          if (state == ENTER_B) nxt_b = neg;
          else                  nxt_a = neg;
          if (cur == 16'sh8000) nxt_ovf = 1'b1;
        end
      end else if (arith) begin
        nxt_op    = operator_input;
        nxt_state = OP_WAIT;
        if (state == ENTER_B) begin
          nxt_a   = res;
          nxt_ovf = eovf;
        end
      end else if (operator_input == 3'b000 && keypad_input < 4'd10) begin
        case (state)
          ENTER_A: if (in_rng) nxt_a = appended[15:0];
          ENTER_B: if (in_rng) nxt_b = appended[15:0];
          OP_WAIT: begin
            nxt_b     = {12'd0, keypad_input};
            nxt_state = ENTER_B;
          end
          default: begin
            nxt_a     = {12'd0, keypad_input};
            nxt_ovf   = 1'b0;
            nxt_state = ENTER_A;
          end
        endcase
      end
    end
  end

  // Handshake: one-cycle acknowledge, rearm only after KeyRdy drops
  always_ff @(posedge clk) begin
    if (!nRST) begin
      KeyRd <= 1'b0;
      armed <= 1'b1;
    end else begin
      KeyRd <= cap;
      if (!KeyRdy)  armed <= 1'b1;
      else if (cap) armed <= 1'b0;
    end
  end

  // State and operand registers
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= ENTER_A;
      acc_a <= '0;
      acc_b <= '0;
      op    <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt_state;
      acc_a <= nxt_a;
      acc_b <= nxt_b;
      op    <= nxt_op;
      ovf   <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_calc_key_engine.sv
// Bench for calc_key_engine: directed key sequences plus random keys,
// checked through an expected-response queue against an integer model.
module tb_calc_key_engine;
  logic        clk = 1'b0;
  logic        nRST;
  logic        KeyRdy;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        KeyRd;
  logic [15:0] display;
  logic        ovf;
  logic        result_valid;

  calc_key_engine dut (
    .clk(clk), .nRST(nRST), .KeyRdy(KeyRdy), .keypad_input(keypad_input),
    .operator_input(operator_input), .equal_input(equal_input),
    .KeyRd(KeyRd), .display(display), .ovf(ovf), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int disp; bit ov; bit rv; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, rd_cnt = 0;
  bit prev_rd = 0;

`ifdef CALC_MUL_EN
  localparam bit MUL_OK = 1'b1;
`else
  localparam bit MUL_OK = 1'b0;
`endif

  // Model: operands as plain integers, phase 0=first operand,
  // 1=operator given, 2=second operand, 3=showing a result
  int ma, mb, mop, mph;
  bit movf;

  function automatic int wrap16(int v);
    int r;
    r = v & 32'hFFFF;
    if (r > 32767) r = r - 65536;
    return r;
  endfunction

  function automatic void m_eval(int x, int y);
    int f;
    if (mop == 1)      f = x + y;
    else if (mop == 2) f = x - y;
    else               f = x * y;
    ma   = wrap16(f);
    movf = (f != ma);
  endfunction

  function automatic int m_app(int v, int d);
    int n;
    n = (v < 0) ? v * 10 - d : v * 10 + d;
    return (n >= -32768 && n <= 32767) ? n : v;
  endfunction

  function automatic void m_reset();
    ma = 0; mb = 0; mop = 0; mph = 0; movf = 0;
  endfunction

  function automatic void m_key(bit eq, int opc, int d);
    bit ar;
    ar = (opc == 1) || (opc == 2) || (opc == 3 && MUL_OK);
    if (eq) begin
      if (mph == 1) begin mb = ma; m_eval(ma, ma); mph = 3; end
      else if (mph >= 2) begin m_eval(ma, mb); mph = 3; end
    end else if (opc == 4) begin
      m_reset();
    end else if (opc == 5) begin
      if (mph == 2) begin
        if (mb == -32768) movf = 1; else mb = -mb;
      end else if (mph != 1) begin
        if (ma == -32768) movf = 1; else ma = -ma;
      end
    end else if (ar) begin
      if (mph == 2) m_eval(ma, mb);
      mop = opc; mph = 1;
    end else if (opc == 0 && d < 10) begin
      if (mph == 0)      ma = m_app(ma, d);
      else if (mph == 2) mb = m_app(mb, d);
      else if (mph == 1) begin mb = d; mph = 2; end
      else begin ma = d; movf = 0; mph = 0; end
    end
  endfunction

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every acknowledge pops one expected response
  always @(negedge clk) begin
    if (nRST) begin
      if (KeyRd) begin
        exp_t e;
        rd_cnt++;
        if (prev_rd) chk("keyrd_width", 2, 1);
        if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_display", int'($signed(display)), e.disp);
          chk("sb_ovf", int'(ovf), int'(e.ov));
          chk("sb_result_valid", int'(result_valid), int'(e.rv));
        end
      end
      prev_rd = KeyRd;
    end else prev_rd = 0;
  end

  task automatic send_key(bit eq, int opc, int d, int hold);
    exp_t e;
    int n;
    m_key(eq, opc, d);
    e.disp = (mph == 2) ? mb : ma;
    e.ov   = movf;
    e.rv   = (mph == 3);
    exp_q.push_back(e);
    equal_input    = eq;
    operator_input = 3'(opc);
    keypad_input   = 4'(d);
    KeyRdy         = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!KeyRd && n < 20);
    if (!KeyRd) begin
      chk("ack_timeout", 0, 1);
      void'(exp_q.pop_back());
    end
    repeat (hold) @(negedge clk);
    KeyRdy = 1'b0;
    keypad_input   = 4'($urandom_range(0, 15));
    operator_input = 3'($urandom_range(0, 7));
    @(negedge clk);
  endtask

  task automatic dk(int d);  send_key(0, 0, d, 0); endtask
  task automatic ok(int o);  send_key(0, o, 0, 0); endtask
  task automatic eqk();      send_key(1, 0, 0, 0); endtask

  task automatic chk_out(string name, int disp, int ov, int rv);
    chk({name, "_display"}, int'($signed(display)), disp);
    chk({name, "_ovf"}, int'(ovf), ov);
    chk({name, "_rv"}, int'(result_valid), rv);
  endtask

  initial begin
    int c0;
    nRST = 1'b0; KeyRdy = 1'b0; keypad_input = '0;
    operator_input = '0; equal_input = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_keyrd", int'(KeyRd), 0);
    chk_out("reset", 0, 0, 0);
    nRST = 1'b1;
    @(negedge clk);

    // 12+3=
    c0 = rd_cnt;
    dk(1); dk(2); ok(1); dk(3); eqk();
    chk_out("add", 15, 0, 1);
    chk("add_acks", rd_cnt - c0, 5);

    // 5-8= =
    ok(4); dk(5); ok(2); dk(8); eqk();
    chk_out("sub", -3, 0, 1);
    eqk();
    chk_out("sub_rep", -11, 0, 1);

    // entry clamp
    ok(4); dk(3); dk(2); dk(7); dk(6); dk(7);
    chk_out("max", 32767, 0, 0);
    dk(8);
    chk_out("clamp", 32767, 0, 0);

    // wrap on add, then new digit clears ovf
    ok(4); dk(3); dk(2); dk(7); dk(6); dk(7); ok(1); dk(1); eqk();
    chk_out("wrap", -32768, 1, 1);
    dk(4);
    chk_out("after_wrap", 4, 0, 0);

    // long KeyRdy hold: single capture
    ok(4);
    c0 = rd_cnt;
    send_key(0, 0, 7, 5);
    chk("hold_acks", rd_cnt - c0, 1);
    chk_out("hold", 7, 0, 0);

    // negate and the -32768 corner
    ok(4); dk(5); ok(5); dk(3);
    chk_out("neg_entry", -53, 0, 0);
    ok(4); dk(3); dk(2); dk(7); dk(6); dk(7); ok(5); ok(2); dk(1); eqk();
    chk_out("min", -32768, 0, 1);
    ok(5);
    chk_out("neg_min", -32768, 1, 1);

    // multiply (or ignored operator)
    ok(4); dk(3); dk(0); dk(0); ok(3); dk(2); dk(0); dk(0); eqk();
    if (MUL_OK) chk_out("mul", -5536, 1, 1);
    else        chk_out("nomul", 30020, 0, 0);

    // random keys
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      send_key(0, 0, $urandom_range(0, 15), $urandom_range(0, 2));
      else if (r < 82) send_key(0, $urandom_range(1, 7), $urandom_range(0, 15), $urandom_range(0, 2));
      else if (r < 95) send_key(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 2));
      else             ok(4);
    end

    // reset while a key is pending
    ok(4); dk(9); dk(1);
    c0 = rd_cnt;
    keypad_input = 4'd5; operator_input = 3'd0; equal_input = 1'b0;
    KeyRdy = 1'b1; nRST = 1'b0;
    @(negedge clk);
    chk("rst_keyrd", int'(KeyRd), 0);
    chk_out("rst_mid", 0, 0, 0);
    KeyRdy = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    m_reset();
    @(negedge clk);
    chk("rst_no_ack", rd_cnt - c0, 0);
    dk(6);
    chk_out("post_rst", 6, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
